cache_refill_ctrl: RTL and testbench

Line-refill engine that sits directly upstream of the cache data/tag stores. It accepts a miss (address plus victim way from the LRU), issues one burst read to backing memory and collects the returned beats. It writes each beat into the chosen way/set, then signals completion so the cache sets the tag valid bit. It replaces the direct combinational RAM read currently used on replacement.

---
 rtl/cache_refill_ctrl.sv | 94 +++++++++
 tb/tb_cache_refill_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: fetches one cache line as a burst read and writes each returned beat into the victim way
module cache_refill_ctrl #(
    parameter int ADDR_WID = 32,
    parameter int WORD_WID = 64,
    parameter int BEATS = 4,
    parameter int WAY_WID = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     miss_valid_i,
    output logic                     miss_ready_o,
    input  logic [ADDR_WID-1:0]      miss_addr_i,
    input  logic [WAY_WID-1:0]       miss_way_i,
    output logic                     mem_req_valid_o,
    input  logic                     mem_req_ready_i,
    output logic [ADDR_WID-1:0]      mem_req_addr_o,
    input  logic                     mem_rsp_valid_i,
    input  logic [WORD_WID-1:0]      mem_rsp_data_i,
    input  logic                     mem_rsp_err_i,
    output logic                     fill_we_o,
    output logic [ADDR_WID-1:0]      fill_addr_o,
    output logic [WAY_WID-1:0]       fill_way_o,
    output logic [$clog2(BEATS)-1:0] fill_beat_o,
    output logic [WORD_WID-1:0]      fill_data_o,
    output logic                     fill_done_o,
    output logic                     fill_err_o,
    output logic                     busy_o
);
    localparam int BW = $clog2(BEATS);
    localparam int OFF = BW + $clog2(WORD_WID / 8);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
    state_t state, state_nxt;
    logic [ADDR_WID-1:0] line_addr;
    logic [WAY_WID-1:0] way;
    logic [BW-1:0] beat_cnt;
    logic [TW-1:0] timer;
    logic err_flag, beat, last, expire;
    assign beat = state == RESP && mem_rsp_valid_i;
    assign last = beat_cnt == BW'(BEATS - 1);
    assign expire = state == RESP && !mem_rsp_valid_i && timer == TW'(TIMEOUT - 1);
    assign mem_req_addr_o = line_addr;
    assign fill_addr_o = line_addr;
    assign fill_way_o = way;
    always_comb begin
        miss_ready_o = state == IDLE;
        mem_req_valid_o = state == REQ;
        busy_o = state != IDLE;
        state_nxt = state == IDLE ? (miss_valid_i ? REQ : IDLE)
                  : state == REQ  ? (mem_req_ready_i ? RESP : REQ)
                  : state == RESP ? (((beat && last) || expire) ? DONE : RESP)
                  : IDLE;
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            line_addr <= '0;
            way <= '0;
            beat_cnt <= '0;
            timer <= '0;
            err_flag <= 1'b0;
            fill_we_o <= 1'b0;
            fill_beat_o <= '0;
            fill_data_o <= '0;
            fill_done_o <= 1'b0;
            fill_err_o <= 1'b0;
        end else begin
            state <= state_nxt;
            fill_we_o <= beat && !mem_rsp_err_i;
            fill_done_o <= state == DONE && !err_flag;
            fill_err_o <= state == DONE && err_flag;
            if (state == IDLE && miss_valid_i) begin
                line_addr <= {miss_addr_i[ADDR_WID-1:OFF], OFF'(0)};
                way <= miss_way_i;
            end
            if (state == REQ) begin
                beat_cnt <= '0;
                timer <= '0;
            end
            if (beat) begin
                beat_cnt <= last ? beat_cnt : beat_cnt + 1'b1;
                timer <= '0;
                fill_beat_o <= beat_cnt;
                fill_data_o <= mem_rsp_data_i;
                err_flag <= err_flag | mem_rsp_err_i;
            end else if (state == RESP) begin
                timer <= timer == TW'(TIMEOUT) ? timer : timer + 1'b1;
                err_flag <= err_flag | expire;
            end
            if (state == DONE) err_flag <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: vector table plus randomized transactions checked against a transaction-level timing model
module tb_cache_refill_ctrl;
    localparam int AW = 32, WW = 64, B = 4, WYW = 2, TO = 8;
    localparam logic [31:0] LMASK = 32'hFFFF_FFE0;
    typedef struct packed {
        logic [31:0] addr;
        logic [1:0] way;
        logic [3:0] d;
        logic [3:0][3:0] gap;
        logic [3:0] err;
        logic hold;
        logic [31:0] exp_line;
        logic exp_err;
    } vec_t;
    logic clk_i = 1'b0, rst_i = 1'b1;
    logic miss_valid_i = 1'b0, mem_req_ready_i = 1'b0, mem_rsp_valid_i = 1'b0, mem_rsp_err_i = 1'b0;
    logic [AW-1:0] miss_addr_i = '0;
    logic [WYW-1:0] miss_way_i = '0;
    logic [WW-1:0] mem_rsp_data_i = '0;
    logic miss_ready_o, mem_req_valid_o, fill_we_o, fill_done_o, fill_err_o, busy_o;
    logic [AW-1:0] mem_req_addr_o, fill_addr_o;
    logic [WYW-1:0] fill_way_o;
    logic [1:0] fill_beat_o;
    logic [WW-1:0] fill_data_o;
    int checks = 0, failures = 0;
    bit skip_pulse = 0;

    cache_refill_ctrl #(.ADDR_WID(AW), .WORD_WID(WW), .BEATS(B), .WAY_WID(WYW), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .miss_valid_i(miss_valid_i), .miss_ready_o(miss_ready_o), .miss_addr_i(miss_addr_i), .miss_way_i(miss_way_i),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i), .mem_req_addr_o(mem_req_addr_o),
        .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_data_i(mem_rsp_data_i), .mem_rsp_err_i(mem_rsp_err_i),
        .fill_we_o(fill_we_o), .fill_addr_o(fill_addr_o), .fill_way_o(fill_way_o), .fill_beat_o(fill_beat_o),
        .fill_data_o(fill_data_o), .fill_done_o(fill_done_o), .fill_err_o(fill_err_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, "_miss_ready"}, 64'(miss_ready_o), 64'(1));
        chk({tag, "_busy"}, 64'(busy_o), 64'(0));
        chk({tag, "_req_valid"}, 64'(mem_req_valid_o), 64'(0));
        chk({tag, "_req_addr"}, 64'(mem_req_addr_o), 64'(0));
        chk({tag, "_we"}, 64'(fill_we_o), 64'(0));
        chk({tag, "_fill_addr"}, 64'(fill_addr_o), 64'(0));
        chk({tag, "_fill_way"}, 64'(fill_way_o), 64'(0));
        chk({tag, "_fill_beat"}, 64'(fill_beat_o), 64'(0));
        chk({tag, "_fill_data"}, fill_data_o, 64'(0));
        chk({tag, "_done"}, 64'(fill_done_o), 64'(0));
        chk({tag, "_err"}, 64'(fill_err_o), 64'(0));
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic [1:0] w, input logic [3:0] d,
                                input logic [3:0] g0, input logic [3:0] g1, input logic [3:0] g2, input logic [3:0] g3,
                                input logic [3:0] er, input logic h, input logic [31:0] ln, input logic ee);
        vec_t v;
        v.addr = a;
        v.way = w;
        v.d = d;
        v.gap = {g3, g2, g1, g0};
        v.err = er;
        v.hold = h;
        v.exp_line = ln;
        v.exp_err = ee;
        return v;
    endfunction

    // k idle cycles, then the miss; d cycles of request stall; gap[i] silent cycles before beat i
    task automatic run_txn(input vec_t v, input int k, input bit strays,
                           output logic [31:0] obs_line, output logic obs_done, output logic obs_err);
        logic [31:0] line;
        logic [63:0] data [B];
        int arr [B];
        bit acc [B];
        int d, p, e, s, idle_start, eb;
        bit errany, ew, hit;
        line = v.addr & LMASK;
        d = int'(v.d);
        idle_start = k + 2 + d;
        p = -1;
        s = -1;
        errany = 0;
        obs_line = '0;
        obs_done = 1'b0;
        obs_err = 1'b0;
        for (int i = 0; i < B; i++) begin
            data[i] = {$urandom, $urandom};
            arr[i] = idle_start + int'(v.gap[i]);
            acc[i] = 0;
            if (p < 0 && int'(v.gap[i]) >= TO) begin
                p = idle_start + TO + 1;
                errany = 1;
                s = i;
            end else if (p < 0) begin
                acc[i] = 1;
                errany |= v.err[i];
                idle_start = arr[i] + 1;
            end
        end
        if (p < 0) p = arr[B-1] + 2;
        e = (s >= 0 && arr[s] > p - 1) ? arr[s] : p - 1;
        for (int t = 0; t <= e; t++) begin
            ew = 0;
            eb = 0;
            for (int i = 0; i < B; i++)
                if (acc[i] && !v.err[i] && arr[i] + 1 == t) begin
                    ew = 1;
                    eb = i;
                end
            chk("miss_ready", 64'(miss_ready_o), 64'(t <= k || t >= p));
            chk("busy", 64'(busy_o), 64'(!(t <= k || t >= p)));
            chk("req_valid", 64'(mem_req_valid_o), 64'(t > k && t <= k + 1 + d));
            if (t > k && t <= k + 1 + d) chk("req_addr", 64'(mem_req_addr_o), 64'(line));
            chk("fill_we", 64'(fill_we_o), 64'(ew));
            if (ew) begin
                chk("fill_beat", 64'(fill_beat_o), 64'(eb));
                chk("fill_data", fill_data_o, data[eb]);
                chk("fill_addr", 64'(fill_addr_o), 64'(line));
                chk("fill_way", 64'(fill_way_o), 64'(v.way));
            end
            if (!(t == 0 && skip_pulse)) begin
                chk("fill_done", 64'(fill_done_o), 64'(t == p && !errany));
                chk("fill_err", 64'(fill_err_o), 64'(t == p && errany));
            end
            if (t == k + 1) obs_line = mem_req_addr_o;
            if (t == p) begin
                obs_done = fill_done_o;
                obs_err = fill_err_o;
            end
            miss_valid_i = (t == k) || (v.hold && t > k && t < p);
            miss_addr_i = t == k ? v.addr : $urandom;
            miss_way_i = t == k ? v.way : 2'($urandom);
            mem_req_ready_i = (t == k + 1 + d) || (strays && t <= k);
            hit = 0;
            mem_rsp_data_i = {$urandom, $urandom};
            mem_rsp_err_i = 1'($urandom);
            for (int i = 0; i < B; i++)
                if ((acc[i] || i == s) && arr[i] == t) begin
                    hit = 1;
                    mem_rsp_data_i = data[i];
                    mem_rsp_err_i = v.err[i];
                end
            mem_rsp_valid_i = hit || (strays && t <= k + 1 + d && $urandom_range(0, 1) == 1);
            tick;
        end
        skip_pulse = (p == e + 1);
        if (skip_pulse) begin
            chk("fill_done", 64'(fill_done_o), 64'(!errany));
            chk("fill_err", 64'(fill_err_o), 64'(errany));
            obs_done = fill_done_o;
            obs_err = fill_err_o;
        end
    endtask

    initial begin
        vec_t vt [7];
        vec_t v;
        logic [31:0] ol;
        logic od, oe;
        int g;
        vt[0] = mk(32'h0000_1234, 2'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, 1'b0, 32'h0000_1220, 1'b0);
        vt[1] = mk(32'hDEAD_BEEF, 2'd1, 4'd5, 4'd0, 4'd1, 4'd0, 4'd2, 4'b0000, 1'b0, 32'hDEAD_BEE0, 1'b0);
        vt[2] = mk(32'h8000_0040, 2'd3, 4'd1, 4'd3, 4'd3, 4'd3, 4'd3, 4'b0010, 1'b0, 32'h8000_0040, 1'b1);
        vt[3] = mk(32'h0000_0FFF, 2'd0, 4'd0, 4'd0, 4'd0, 4'd9, 4'd0, 4'b0000, 1'b0, 32'h0000_0FE0, 1'b1);
        vt[4] = mk(32'h1000_003F, 2'd2, 4'd2, 4'd7, 4'd0, 4'd7, 4'd0, 4'b0000, 1'b1, 32'h1000_0020, 1'b0);
        vt[5] = mk(32'hFFFF_FFFF, 2'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'b1000, 1'b1, 32'hFFFF_FFE0, 1'b1);
        vt[6] = mk(32'h0000_0020, 2'd3, 4'd3, 4'd8, 4'd0, 4'd0, 4'd0, 4'b0000, 1'b1, 32'h0000_0020, 1'b1);
        repeat (3) tick;
        reset_chk("reset");
        rst_i = 1'b0;
        tick;
        reset_chk("release");
        for (int i = 0; i < 7; i++) begin
            run_txn(vt[i], i % 3, (i % 2) == 1, ol, od, oe);
            chk("vec_line", 64'(ol), 64'(vt[i].exp_line));
            chk("vec_done", 64'(od), 64'(!vt[i].exp_err));
            chk("vec_err", 64'(oe), 64'(vt[i].exp_err));
        end
        miss_valid_i = 1'b1;
        miss_addr_i = 32'h0000_5678;
        miss_way_i = 2'd1;
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_err_i = 1'b0;
        tick;
        chk("rst_seq_req_valid", 64'(mem_req_valid_o), 64'(1));
        chk("rst_seq_req_addr", 64'(mem_req_addr_o), 64'h5660);
        miss_valid_i = 1'b0;
        mem_req_ready_i = 1'b1;
        tick;
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i = 64'hB0;
        tick;
        mem_rsp_data_i = 64'hB1;
        tick;
        mem_rsp_valid_i = 1'b0;
        chk("rst_seq_we", 64'(fill_we_o), 64'(1));
        chk("rst_seq_beat", 64'(fill_beat_o), 64'(1));
        chk("rst_seq_data", fill_data_o, 64'hB1);
        #2 rst_i = 1'b1;
        #1 reset_chk("async_rst");
        tick;
        reset_chk("in_rst");
        rst_i = 1'b0;
        tick;
        reset_chk("after_rst");
        skip_pulse = 0;
        run_txn(vt[0], 1, 1'b1, ol, od, oe);
        chk("post_rst_line", 64'(ol), 64'(vt[0].exp_line));
        chk("post_rst_done", 64'(od), 64'(1));
        for (int n = 0; n < 200; n++) begin
            v.addr = $urandom;
            v.way = 2'($urandom);
            v.d = 4'($urandom_range(0, 3));
            for (int j = 0; j < B; j++) begin
                g = $urandom_range(0, 3);
                if ($urandom_range(0, 9) == 0) g = $urandom_range(TO - 1, TO + 2);
                v.gap[j] = 4'(g);
                v.err[j] = $urandom_range(0, 5) == 0;
            end
            v.hold = 1'($urandom);
            v.exp_line = v.addr & LMASK;
            v.exp_err = 1'b0;
            run_txn(v, $urandom_range(0, 2), $urandom_range(0, 1) == 1, ol, od, oe);
            chk("rnd_line", 64'(ol), 64'(v.exp_line));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
